// File: rtl/ls_mem_responder.sv
// Load/store memory responder: single-port word array fronted by a FIFO store
// buffer, with youngest-entry store-to-load forwarding and one-cycle loads.
module ls_mem_responder #(
    parameter int AW       = 8,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [15:0] mem_read_data,
    output logic        rd_valid,
    output logic        sb_full,
    output logic        sb_empty,
    output logic        err_overflow,
    output logic        err_conflict
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   mem_r     [2**AW];
    logic [AW-1:0] sb_idx_r  [SB_DEPTH];
    logic [15:0]   sb_data_r [SB_DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic [AW-1:0] addr_s;
    logic          load_s;
    logic          drain_s;
    logic          enq_s;
    logic          fwd_hit_s;
    logic [15:0]   fwd_data_s;
    logic [PW-1:0] slot_s;

    assign addr_s   = mem_addr[AW-1:0];
    assign sb_full  = (count_r == CW'(SB_DEPTH));
    assign sb_empty = (count_r == {CW{1'b0}});

    // Request decode and buffer search; scanning oldest to youngest lets the youngest hit win.
    always_comb begin
        load_s     = mem_read_en & ~mem_write_en;
        drain_s    = (count_r != {CW{1'b0}}) & ~mem_read_en;
        enq_s      = mem_write_en & ((count_r < CW'(SB_DEPTH)) | drain_s);
        fwd_hit_s  = 1'b0;
        fwd_data_s = 16'h0000;
        slot_s     = head_r;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot_s = head_r + PW'(i);
            if ((CW'(i) < count_r) && (sb_idx_r[slot_s] == addr_s)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = sb_data_r[slot_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Storage writes: buffer slot on enqueue, array word on drain; contents are never reset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            sb_idx_r[tail_r]  <= addr_s;
            sb_data_r[tail_r] <= mem_write_data;
        end
        if (drain_s) begin
            mem_r[sb_idx_r[head_r]] <= sb_data_r[head_r];
        end
    end

    // Buffer pointers and occupancy; power-of-two depth gives modulo wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (drain_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({enq_s, drain_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered load return and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_data <= 16'h0000;
            rd_valid      <= 1'b0;
            err_overflow  <= 1'b0;
            err_conflict  <= 1'b0;
        end else begin
            rd_valid     <= load_s;
            err_overflow <= mem_write_en & ~enq_s;
            err_conflict <= mem_read_en & mem_write_en;
            if (load_s) begin
                mem_read_data <= fwd_hit_s ? fwd_data_s : mem_r[addr_s];
            end
        end
    end

endmodule

// File: tb/tb_ls_mem_responder.sv
// Directed bench for ls_mem_responder: queue/array reference model checked every
// cycle, plus literal expectations pinned at key points of each scenario.
module tb_ls_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] mem_write_data = 16'h0000;
    logic        mem_write_en = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [15:0] mem_read_data;
    logic        rd_valid, sb_full, sb_empty, err_overflow, err_conflict;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] data;
    } ent_t;

    ent_t        sbq[$];
    logic [15:0] mm[256];
    bit          known[256];
    logic [15:0] m_rdata;
    bit          m_rv, m_ovf, m_conf, m_known;

    ls_mem_responder #(.AW(8), .SB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .rd_valid(rd_valid),
        .sb_full(sb_full), .sb_empty(sb_empty),
        .err_overflow(err_overflow), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        m_rdata = 16'h0000;
        m_rv    = 1'b0;
        m_ovf   = 1'b0;
        m_conf  = 1'b0;
        m_known = 1'b1;
    endtask

    // Expected outputs after the coming clock edge, from the request rules.
    task automatic model_step(input bit re, input bit we, input logic [15:0] a, input logic [15:0] d);
        logic [7:0] ix;
        bit         hit, dr;
        ent_t       e;
        ix   = a[7:0];
        dr   = (sbq.size() > 0) && !re;
        m_rv = re && !we;
        m_conf = re && we;
        if (m_rv) begin
            hit = 1'b0;
            for (int i = sbq.size() - 1; i >= 0 && !hit; i--) begin
                if (sbq[i].idx == ix) begin
                    hit = 1'b1;
                    m_rdata = sbq[i].data;
                    m_known = 1'b1;
                end
            end
            if (!hit) begin
                m_rdata = mm[ix];
                m_known = known[ix];
            end
        end
        if (dr) begin
            e = sbq.pop_front();
            mm[e.idx] = e.data;
            known[e.idx] = 1'b1;
        end
        m_ovf = 1'b0;
        if (we) begin
            if (sbq.size() < 4) begin
                e.idx = ix;
                e.data = d;
                sbq.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle of requests; returns just after the next falling edge.
    task automatic cyc(input bit re, input bit we, input logic [15:0] a, input logic [15:0] d);
        mem_read_en    = re;
        mem_write_en   = we;
        mem_addr       = a;
        mem_write_data = d;
        model_step(re, we, a, d);
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        #1;
        chk("rd_valid", {15'h0, rd_valid}, {15'h0, m_rv});
        chk("err_overflow", {15'h0, err_overflow}, {15'h0, m_ovf});
        chk("err_conflict", {15'h0, err_conflict}, {15'h0, m_conf});
        chk("sb_full", {15'h0, sb_full}, {15'h0, (sbq.size() == 4)});
        chk("sb_empty", {15'h0, sb_empty}, {15'h0, (sbq.size() == 0)});
        if (m_known) chk("mem_read_data", mem_read_data, m_rdata);
    end

    initial begin
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("reset sb_empty", {15'h0, sb_empty}, 16'h0001);
        chk("reset rdata", mem_read_data, 16'h0000);
        rst = 1'b0;

        // Store, let it drain, then load from the array.
        cyc(1'b0, 1'b1, 16'h00A5, 16'hBEEF);
        chk("st1 sb_empty", {15'h0, sb_empty}, 16'h0000);
        idle(2);
        chk("drained sb_empty", {15'h0, sb_empty}, 16'h0001);
        cyc(1'b1, 1'b0, 16'h00A5, 16'h0000);
        chk("ld A5 valid", {15'h0, rd_valid}, 16'h0001);
        chk("ld A5 data", mem_read_data, 16'hBEEF);
        idle(1);
        chk("hold valid", {15'h0, rd_valid}, 16'h0000);
        chk("hold data", mem_read_data, 16'hBEEF);

        // Forwarding from a still-buffered store.
        cyc(1'b0, 1'b1, 16'h0010, 16'h1111);
        cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("fwd 10", mem_read_data, 16'h1111);
        idle(1);
        chk("fwd drained", {15'h0, sb_empty}, 16'h0001);

        // Same-index stores: youngest forwarded, youngest retained.
        cyc(1'b0, 1'b1, 16'h0003, 16'hAAAA);
        cyc(1'b0, 1'b1, 16'h0003, 16'hBBBB);
        cyc(1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("young fwd", mem_read_data, 16'hBBBB);
        idle(3);
        cyc(1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("young array", mem_read_data, 16'hBBBB);

        // Loads block drain: fill, overflow, then forward from a full buffer.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 16'h0040 + 16'(i), 16'hC000 + 16'(i));
            if (i == 3) chk("full after 4", {15'h0, sb_full}, 16'h0001);
        end
        chk("overflow pulse", {15'h0, err_overflow}, 16'h0001);
        chk("still full", {15'h0, sb_full}, 16'h0001);
        cyc(1'b1, 1'b0, 16'h0042, 16'h0000);
        chk("fwd full", mem_read_data, 16'hC002);
        chk("ovf cleared", {15'h0, err_overflow}, 16'h0000);
        idle(5);
        cyc(1'b1, 1'b0, 16'h0044, 16'h0000);
        chk("dropped store", {15'h0, rd_valid}, 16'h0001);

        // Conflict: store kept, load ignored.
        cyc(1'b1, 1'b1, 16'h0020, 16'h5A5A);
        chk("conflict no valid", {15'h0, rd_valid}, 16'h0000);
        chk("conflict pulse", {15'h0, err_conflict}, 16'h0001);
        idle(2);
        cyc(1'b1, 1'b0, 16'h0020, 16'h0000);
        chk("conflict data", mem_read_data, 16'h5A5A);

        // Upper address bits alias onto the low index.
        cyc(1'b0, 1'b1, 16'h1234, 16'h7E57);
        cyc(1'b1, 1'b0, 16'h0034, 16'h0000);
        chk("alias fwd", mem_read_data, 16'h7E57);
        idle(2);
        cyc(1'b1, 1'b0, 16'hFF34, 16'h0000);
        chk("alias array", mem_read_data, 16'h7E57);

        // Reset with buffered stores discards them; array survives.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h0050 + 16'(i), 16'hD000);
        chk("pre-rst count", {15'h0, sb_empty}, 16'h0000);
        rst = 1'b1;
        mem_read_en = 1'b0;
        mem_write_en = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk("rst sb_empty", {15'h0, sb_empty}, 16'h0001);
        chk("rst rdata", mem_read_data, 16'h0000);
        chk("rst conflict", {15'h0, err_conflict}, 16'h0000);
        idle(2);
        chk("post-rst valid", {15'h0, rd_valid}, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("array kept", mem_read_data, 16'hBBBB);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
